// File: rtl/rs_dispatch_scheduler.sv
// Reservation-station bank and single-issue dispatch controller for one add/sub FU.
// Entries wait for operands from the CDB, dispatch round-robin, and hand results off via valid/ready.
module rs_dispatch_scheduler #(
  parameter int ENTRIES  = 4,
  parameter int TAG_W    = 3,
  parameter int DATA_W   = 16,
  parameter int BASE_TAG = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [3:0]        issue_op,
  input  logic [DATA_W-1:0] issue_vj,
  input  logic [DATA_W-1:0] issue_vk,
  input  logic              issue_rj,
  input  logic              issue_rk,
  input  logic [TAG_W-1:0]  issue_qj,
  input  logic [TAG_W-1:0]  issue_qk,
  output logic [TAG_W-1:0]  issue_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              fu_instruct,
  output logic [15:0]       fu_instruction,
  output logic [TAG_W-1:0]  fu_code,
  output logic [DATA_W-1:0] fu_reg1,
  output logic [DATA_W-1:0] fu_reg2,
  input  logic              fu_done,
  input  logic [TAG_W-1:0]  fu_code_in,
  input  logic [DATA_W-1:0] fu_dout,
  output logic              res_valid,
  output logic [TAG_W-1:0]  res_tag,
  output logic [DATA_W-1:0] res_data,
  input  logic              res_ready,
  output logic [3:0]        busy_count
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef enum logic [1:0] {IDLE, DISPATCH, WAIT, RESULT} state_t;

  state_t             state;
  logic [ENTRIES-1:0] busy, exec, rj, rk, ready;
  logic [3:0]         op [ENTRIES];
  logic [DATA_W-1:0]  vj [ENTRIES];
  logic [DATA_W-1:0]  vk [ENTRIES];
  logic [TAG_W-1:0]   qj [ENTRIES];
  logic [TAG_W-1:0]   qk [ENTRIES];
  logic [IDX_W-1:0]   rr, cur;

  logic             free_found, sel_found, fire, byp_j, byp_k;
  logic [IDX_W-1:0] free_idx, sel_idx, probe;

  // NOTE: combinational blocks use blocking '=' and assign every output a default
  // before any conditional, so no storage (latch) is inferred.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign ready = busy & ~exec & rj & rk;

  // Round-robin: first ready entry at or after rr, wrapping.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    probe     = '0;
    for (int k = 0; k < ENTRIES; k++) begin
      probe = IDX_W'((int'(rr) + k) % ENTRIES);
      if (!sel_found && ready[probe]) begin
        sel_found = 1'b1;
        sel_idx   = probe;
      end
    end
  end

  always_comb begin
    busy_count = '0;
    for (int i = 0; i < ENTRIES; i++) busy_count = busy_count + {3'b000, busy[i]};
  end

  assign issue_ready = free_found;
  assign issue_tag   = TAG_W'(BASE_TAG) + TAG_W'(free_idx);
  assign fire        = issue_valid && free_found;
  assign byp_j       = !issue_rj && cdb_valid && (issue_qj == cdb_tag);
  assign byp_k       = !issue_rk && cdb_valid && (issue_qk == cdb_tag);

  // NOTE: operand payload has no reset; it is only observed through busy, which is reset,
  // so clearing the storage array would add reset fan-out without changing behaviour.
  always_ff @(posedge clock) begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (fire && free_idx == IDX_W'(i)) begin
        op[i] <= issue_op;
        vj[i] <= byp_j ? cdb_data : issue_vj;
        vk[i] <= byp_k ? cdb_data : issue_vk;
        rj[i] <= issue_rj || byp_j;
        rk[i] <= issue_rk || byp_k;
        qj[i] <= issue_qj;
        qk[i] <= issue_qk;
      end else if (busy[i] && cdb_valid) begin
        if (!rj[i] && qj[i] == cdb_tag) begin
          vj[i] <= cdb_data;
          rj[i] <= 1'b1;
        end
        if (!rk[i] && qk[i] == cdb_tag) begin
          vk[i] <= cdb_data;
          rk[i] <= 1'b1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      busy           <= '0;
      exec           <= '0;
      rr             <= '0;
      cur            <= '0;
      fu_instruct    <= 1'b0;
      fu_instruction <= '0;
      fu_code        <= '0;
      fu_reg1        <= '0;
      fu_reg2        <= '0;
      res_valid      <= 1'b0;
      res_tag        <= '0;
      res_data       <= '0;
    end else begin
      // The entry being freed is still busy this cycle, so issue never lands on it.
      if (fire) busy[free_idx] <= 1'b1;
      case (state)
        IDLE: begin
          if (sel_found) begin
            exec[sel_idx]  <= 1'b1;
            cur            <= sel_idx;
            fu_code        <= TAG_W'(BASE_TAG) + TAG_W'(sel_idx);
            fu_reg1        <= vj[sel_idx];
            fu_reg2        <= vk[sel_idx];
            fu_instruction <= {12'b0, op[sel_idx]};
            fu_instruct    <= 1'b1;
            state          <= DISPATCH;
          end
        end
        DISPATCH: begin
          fu_instruct <= 1'b0;
          state       <= WAIT;
        end
        WAIT: begin
          // fu_done is sticky; the echoed code distinguishes a fresh completion.
          if (fu_done && fu_code_in == fu_code) begin
            res_valid <= 1'b1;
            res_tag   <= fu_code;
            res_data  <= fu_dout;
            state     <= RESULT;
          end
        end
        RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy[cur] <= 1'b0;
            exec[cur] <= 1'b0;
            rr        <= (cur == IDX_W'(ENTRIES - 1)) ? '0 : cur + 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rs_dispatch_scheduler.sv
// Bench for rs_dispatch_scheduler: per-tag expected-result queues filled by a reference model
// and drained by an independent monitor, plus directed checks of ordering, bypass and reset.
module tb_rs_dispatch_scheduler;
  localparam int ENTRIES  = 4;
  localparam int TAG_W    = 3;
  localparam int DATA_W   = 16;
  localparam int BASE_TAG = 1;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              issue_valid, issue_ready, issue_rj, issue_rk;
  logic [3:0]        issue_op;
  logic [DATA_W-1:0] issue_vj, issue_vk;
  logic [TAG_W-1:0]  issue_qj, issue_qk, issue_tag;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              fu_instruct, fu_done;
  logic [15:0]       fu_instruction;
  logic [TAG_W-1:0]  fu_code, fu_code_in;
  logic [DATA_W-1:0] fu_reg1, fu_reg2, fu_dout;
  logic              res_valid, res_ready;
  logic [TAG_W-1:0]  res_tag;
  logic [DATA_W-1:0] res_data;
  logic [3:0]        busy_count;

  always #5 clock = ~clock;

  rs_dispatch_scheduler #(.ENTRIES(ENTRIES), .TAG_W(TAG_W), .DATA_W(DATA_W), .BASE_TAG(BASE_TAG)) dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_vj(issue_vj), .issue_vk(issue_vk), .issue_rj(issue_rj), .issue_rk(issue_rk),
    .issue_qj(issue_qj), .issue_qk(issue_qk), .issue_tag(issue_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .fu_instruct(fu_instruct), .fu_instruction(fu_instruction), .fu_code(fu_code),
    .fu_reg1(fu_reg1), .fu_reg2(fu_reg2), .fu_done(fu_done), .fu_code_in(fu_code_in),
    .fu_dout(fu_dout), .res_valid(res_valid), .res_tag(res_tag), .res_data(res_data),
    .res_ready(res_ready), .busy_count(busy_count)
  );

  // One-cycle add/sub FU with sticky done; unknown opcodes leave dout stale.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      fu_done <= 1'b0; fu_code_in <= '0; fu_dout <= '0;
    end else if (fu_instruct) begin
      fu_done    <= 1'b1;
      fu_code_in <= fu_code;
      case (fu_instruction[3:0])
        4'd0:    fu_dout <= fu_reg1 + fu_reg2;
        4'd1:    fu_dout <= fu_reg1 - fu_reg2;
        default: ;
      endcase
    end
  end

  typedef struct packed { logic [3:0] op; logic [15:0] a; logic [15:0] b; } exp_t;
  exp_t exp_q [ENTRIES][$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic fail_now(input string msg);
    n_checks++;
    n_fail++;
    $display("FAIL %s", msg);
  endtask

  // Reference model: what each tag holds, indexed by tag - BASE_TAG.
  bit          m_busy [ENTRIES];
  bit          m_rj [ENTRIES], m_rk [ENTRIES], m_pushed [ENTRIES];
  logic [3:0]  m_op [ENTRIES];
  logic [15:0] m_vj [ENTRIES], m_vk [ENTRIES];
  logic [2:0]  m_qj [ENTRIES], m_qk [ENTRIES];

  // Monitor state.
  int          n_disp = 0;
  int          disp_log [$];
  bit          outstanding = 0;
  int          inflight = 0;
  logic [15:0] last_res = 0, last_acc = 0, prev_data = 0, mon_exp;
  bit          prev_hold = 0;
  logic [2:0]  prev_tag = 0;
  int          mon_idx;
  exp_t        mon_e;

  function automatic int model_busy();
    int n = 0;
    for (int i = 0; i < ENTRIES; i++) if (m_busy[i]) n++;
    return n;
  endfunction

  always @(negedge clock) begin
    if (!reset) begin
      if (prev_hold) begin
        check("res_hold_valid", int'(res_valid), 1);
        check("res_hold_tag", int'(res_tag), int'(prev_tag));
        check("res_hold_data", int'(res_data), int'(prev_data));
      end
      prev_hold = res_valid && !res_ready;
      prev_tag  = res_tag;
      prev_data = res_data;
      if (fu_instruct) begin
        n_disp++;
        disp_log.push_back(int'(fu_code));
        check("single_in_flight", int'(outstanding), 0);
        mon_idx = int'(fu_code) - BASE_TAG;
        if (mon_idx < 0 || mon_idx >= ENTRIES || exp_q[mon_idx].size() == 0) begin
          fail_now($sformatf("dispatch_tag: fu_code=%0d has no ready entry", fu_code));
        end else begin
          mon_e = exp_q[mon_idx][0];
          check("fu_reg1", int'(fu_reg1), int'(mon_e.a));
          check("fu_reg2", int'(fu_reg2), int'(mon_e.b));
          check("fu_instruction", int'(fu_instruction), int'(mon_e.op));
          outstanding = 1;
          inflight    = mon_idx;
        end
      end
      if (res_valid && res_ready) begin
        mon_idx = int'(res_tag) - BASE_TAG;
        if (mon_idx < 0 || mon_idx >= ENTRIES || exp_q[mon_idx].size() == 0) begin
          fail_now($sformatf("res_tag: tag=%0d has no expected result", res_tag));
        end else begin
          mon_e   = exp_q[mon_idx].pop_front();
          mon_exp = (mon_e.op == 4'd0) ? mon_e.a + mon_e.b :
                    (mon_e.op == 4'd1) ? mon_e.a - mon_e.b : last_res;
          check("res_data", int'(res_data), int'(mon_exp));
          last_res = mon_exp;
        end
        last_acc    = res_data;
        outstanding = 0;
      end
    end
  end

  // One clock: check combinational status against the model, then step the model on the edge.
  task automatic tick();
    int nfree = 0;
    int low = -1;
    bit fire, hs;
    #1;
    for (int i = 0; i < ENTRIES; i++) if (!m_busy[i]) begin nfree++; if (low < 0) low = i; end
    check("issue_ready", int'(issue_ready), (nfree > 0) ? 1 : 0);
    check("issue_tag", int'(issue_tag), (low < 0) ? BASE_TAG : BASE_TAG + low);
    check("busy_count", int'(busy_count), ENTRIES - nfree);
    fire = issue_valid && (nfree > 0);
    hs   = res_valid && res_ready;
    @(posedge clock);
    if (hs) begin m_busy[inflight] = 0; m_pushed[inflight] = 0; end
    if (cdb_valid) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (m_busy[i]) begin
          if (!m_rj[i] && m_qj[i] == cdb_tag) begin m_vj[i] = cdb_data; m_rj[i] = 1; end
          if (!m_rk[i] && m_qk[i] == cdb_tag) begin m_vk[i] = cdb_data; m_rk[i] = 1; end
        end
      end
    end
    if (fire) begin
      m_busy[low] = 1; m_pushed[low] = 0; m_op[low] = issue_op;
      m_qj[low] = issue_qj; m_qk[low] = issue_qk;
      m_rj[low] = issue_rj || (cdb_valid && issue_qj == cdb_tag);
      m_rk[low] = issue_rk || (cdb_valid && issue_qk == cdb_tag);
      m_vj[low] = (!issue_rj && cdb_valid && issue_qj == cdb_tag) ? cdb_data : issue_vj;
      m_vk[low] = (!issue_rk && cdb_valid && issue_qk == cdb_tag) ? cdb_data : issue_vk;
    end
    for (int i = 0; i < ENTRIES; i++) begin
      if (m_busy[i] && m_rj[i] && m_rk[i] && !m_pushed[i]) begin
        exp_q[i].push_back('{op: m_op[i], a: m_vj[i], b: m_vk[i]});
        m_pushed[i] = 1;
      end
    end
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((model_busy() != 0 || outstanding) && n < budget) begin tick(); n++; end
    if (n >= budget) fail_now("wait_idle: cycle budget expired");
  endtask

  task automatic set_issue(input logic [3:0] op, input logic [15:0] vj, input logic [15:0] vk,
                           input logic rj, input logic rk, input logic [2:0] qj, input logic [2:0] qk);
    issue_valid = 1; issue_op = op; issue_vj = vj; issue_vk = vk;
    issue_rj = rj; issue_rk = rk; issue_qj = qj; issue_qk = qk;
  endtask

  task automatic reset_now();
    reset = 1;
    issue_valid = 0; cdb_valid = 0; res_ready = 0;
    for (int i = 0; i < ENTRIES; i++) begin m_busy[i] = 0; m_pushed[i] = 0; exp_q[i].delete(); end
    outstanding = 0; prev_hold = 0; last_res = 0;
    #1;
  endtask

  task automatic reset_release();
    @(posedge clock); #1;
    reset = 0;
  endtask

  int d0;

  initial begin
    set_issue(0, 0, 0, 0, 0, 0, 0);
    issue_valid = 0; cdb_valid = 0; cdb_tag = 0; cdb_data = 0; res_ready = 0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_fu_instruct", int'(fu_instruct), 0);
    check("rst_fu_instruction", int'(fu_instruction), 0);
    check("rst_fu_code", int'(fu_code), 0);
    check("rst_fu_reg1", int'(fu_reg1), 0);
    check("rst_fu_reg2", int'(fu_reg2), 0);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_res_tag", int'(res_tag), 0);
    check("rst_res_data", int'(res_data), 0);
    check("rst_busy_count", int'(busy_count), 0);
    check("rst_issue_ready", int'(issue_ready), 1);
    check("rst_issue_tag", int'(issue_tag), 1);
    reset = 0;

    // Simple add: 3 edges from ready to res_valid, result held while res_ready is low.
    set_issue(0, 5, 7, 1, 1, 0, 0);
    #1 check("t1_issue_tag", int'(issue_tag), 1);
    d0 = n_disp;
    tick(); issue_valid = 0;
    repeat (2) tick();
    check("t1_not_yet_valid", int'(res_valid), 0);
    tick();
    check("t1_res_valid", int'(res_valid), 1);
    check("t1_one_dispatch", n_disp - d0, 1);
    check("t1_res_tag", int'(res_tag), 1);
    check("t1_res_data", int'(res_data), 12);
    repeat (3) tick();
    check("t1_held_valid", int'(res_valid), 1);
    check("t1_held_data", int'(res_data), 12);
    res_ready = 1; tick(); res_ready = 0;
    check("t1_freed_valid", int'(res_valid), 0);
    check("t1_freed_busy", int'(busy_count), 0);

    // Sub waiting on tag 3 from the CDB.
    set_issue(1, 20, 0, 1, 0, 0, 3);
    tick(); issue_valid = 0;
    d0 = n_disp;
    repeat (4) tick();
    check("t2_no_dispatch", n_disp - d0, 0);
    cdb_valid = 1; cdb_tag = 3; cdb_data = 6;
    tick(); cdb_valid = 0;
    tick();
    check("t2_dispatch_strobe", int'(fu_instruct), 1);
    res_ready = 1;
    wait_idle(20);
    check("t2_res_data", int'(last_acc), 14);

    // Unknown opcode returns the stale FU output.
    set_issue(5, 100, 1, 1, 1, 0, 0);
    tick(); issue_valid = 0;
    wait_idle(20);
    check("stale_dout", int'(last_acc), 14);

    // Fill all entries; a fifth request is ignored; dispatch order 1,2,3,4.
    disp_log.delete();
    for (int k = 0; k < 4; k++) begin set_issue(0, 16'(k * 10 + 1), 16'(k), 1, 1, 0, 0); tick(); end
    check("t3_full_ready", int'(issue_ready), 0);
    check("t3_full_count", int'(busy_count), 4);
    set_issue(0, 99, 99, 1, 1, 0, 0);
    tick(); issue_valid = 0;
    wait_idle(60);
    check("t3_order_len", disp_log.size(), 4);
    if (disp_log.size() == 4) for (int i = 0; i < 4; i++) check("t3_order", disp_log[i], i + 1);

    // Tag 2 freed and reissued while tag 1 waits; rr=2 wraps so tag 1 goes before new tag 2.
    disp_log.delete();
    set_issue(0, 1, 1, 0, 1, 7, 0); tick();
    set_issue(0, 2, 2, 1, 1, 0, 0); tick(); issue_valid = 0;
    d0 = 0;
    while ((model_busy() != 1 || outstanding) && d0 < 20) begin tick(); d0++; end
    if (d0 >= 20) fail_now("rr: tag 2 never completed");
    check("rr_reuse_tag", int'(issue_tag), 2);
    set_issue(0, 3, 3, 1, 1, 0, 0);
    cdb_valid = 1; cdb_tag = 7; cdb_data = 10;
    tick(); issue_valid = 0; cdb_valid = 0;
    wait_idle(40);
    check("rr_order_len", disp_log.size(), 3);
    if (disp_log.size() == 3) begin
      check("rr_order0", disp_log[0], 2);
      check("rr_order1", disp_log[1], 1);
      check("rr_order2", disp_log[2], 2);
    end

    // Issue-cycle bypass of 0xFFFF, add 1 wraps to 0.
    set_issue(0, 16'h1234, 1, 0, 1, 2, 0);
    cdb_valid = 1; cdb_tag = 2; cdb_data = 16'hFFFF;
    tick(); issue_valid = 0; cdb_valid = 0;
    wait_idle(20);
    check("bypass_wrap", int'(last_acc), 0);

    // Pending result blocks any further dispatch.
    res_ready = 0; d0 = n_disp;
    set_issue(0, 4, 4, 1, 1, 0, 0); tick();
    set_issue(1, 9, 2, 1, 1, 0, 0); tick(); issue_valid = 0;
    repeat (8) tick();
    check("hold_one_dispatch", n_disp - d0, 1);
    check("hold_res_valid", int'(res_valid), 1);
    res_ready = 1;
    wait_idle(40);
    check("hold_both_done", n_disp - d0, 2);

    // Reset in WAIT with 3 busy entries.
    res_ready = 0;
    for (int k = 0; k < 3; k++) begin set_issue(0, 16'(k), 1, 1, 1, 0, 0); tick(); end
    issue_valid = 0;
    check("wait_busy3", int'(busy_count), 3);
    reset_now();
    check("wait_rst_instruct", int'(fu_instruct), 0);
    check("wait_rst_res_valid", int'(res_valid), 0);
    check("wait_rst_busy", int'(busy_count), 0);
    check("wait_rst_tag", int'(issue_tag), 1);
    reset_release();

    // Reset during DISPATCH kills the strobe at once.
    set_issue(0, 1, 2, 1, 1, 0, 0); tick(); issue_valid = 0; tick();
    check("disp_strobe_up", int'(fu_instruct), 1);
    reset_now();
    check("disp_rst_instruct", int'(fu_instruct), 0);
    reset_release();

    // Reset during RESULT drops the pending result.
    set_issue(0, 1, 2, 1, 1, 0, 0); tick(); issue_valid = 0; repeat (3) tick();
    check("result_valid_up", int'(res_valid), 1);
    reset_now();
    check("result_rst_valid", int'(res_valid), 0);
    reset_release();

    // Randomized traffic.
    repeat (400) begin
      issue_valid = ($urandom_range(0, 1) == 1);
      issue_op    = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(2, 15)) : 4'($urandom_range(0, 1));
      issue_vj    = 16'($urandom); issue_vk = 16'($urandom);
      issue_rj    = ($urandom_range(0, 3) != 0); issue_rk = ($urandom_range(0, 3) != 0);
      issue_qj    = 3'($urandom_range(0, 7)); issue_qk = 3'($urandom_range(0, 7));
      cdb_valid   = ($urandom_range(0, 9) < 3);
      cdb_tag     = 3'($urandom_range(0, 7)); cdb_data = 16'($urandom);
      res_ready   = ($urandom_range(0, 1) == 1);
      tick();
    end
    issue_valid = 0; res_ready = 1; d0 = 0;
    while ((model_busy() != 0 || outstanding) && d0 < 400) begin
      cdb_valid = 1; cdb_tag = 3'(d0); cdb_data = 16'($urandom);
      tick(); d0++;
    end
    cdb_valid = 0;
    if (d0 >= 400) fail_now("drain: cycle budget expired");
    tick();
    check("final_busy", int'(busy_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
